// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 ops, FSM states, timing constants.
package mdu_pkg;

    localparam int MDU_ITERS   = 32;
    localparam int MDU_LATENCY = 36;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, ITER, NEG_R, DONE, SKIP
    } mdu_state_e;

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide sequencer (slave).
interface mdu_seq_if #(parameter int XLEN = 32);

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1, rs2, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, output busy, done, result);

endinterface

// File: rtl/RCA32bit.sv
// 32-bit ripple-carry adder/subtractor; addsub=1 computes a-b with cout as the no-borrow flag.
module RCA32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        addsub,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] c;
    logic [31:0] bx;

    assign bx   = b ^ {32{addsub}};
    assign c[0] = addsub;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout = c[32];

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M sequencer sharing one RCA32bit across negation, shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: zero operands skip straight to DONE via a one-cycle SKIP state.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic         clk,
    input  logic         rst,
    mdu_seq_if.slave     bus
);

    mdu_state_e      state, state_nxt, start_tgt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic            s1n, s2n;
    logic [XLEN-1:0] hi, lo, mcand, result_q;
    logic [4:0]      cnt;
    logic            busy, done;

    logic [XLEN-1:0] add_a, add_b, sum;
    logic            add_sub, cout;

    logic            is_div;
    logic [XLEN:0]   rp, mul_acc;
    logic [XLEN-1:0] mag, res_pre, res_fin, early_res;
    logic            res_neg;

    RCA32bit u_rca (.a(add_a), .b(add_b), .addsub(add_sub), .sum(sum), .cout(cout));

    assign is_div  = op_q[2];
    assign rp      = {hi, lo[XLEN-1]};
    assign mul_acc = lo[0] ? {cout, sum} : {1'b0, hi};

`ifdef MDU_EARLY_OUT_EN
    assign start_tgt = (bus.rs1 == '0 || bus.rs2 == '0) ? SKIP : NEG_A;
`else
    assign start_tgt = NEG_A;
`endif

    // MUL/DIV* keep their answer in lo; MULH*/REM* in hi
    always_comb begin
        res_pre = (op_q == MDU_MUL || is_div && !op_q[1]) ? lo : hi;
        res_neg = 1'b0;
        if (is_div) res_neg = op_q[1] ? s1n : ((s1n ^ s2n) && mcand != '0);
        else if (op_q != MDU_MUL) res_neg = s1n ^ s2n;
        if (!res_neg) res_fin = res_pre;
        else if (!is_div && lo != '0) res_fin = ~hi;
        else res_fin = sum;
    end

    always_comb begin
        early_res = '0;
        if (is_div && rs2_q == '0) early_res = op_q[1] ? rs1_q : '1;
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        unique case (state)
            NEG_A: begin add_b = rs1_q; add_sub = 1'b1; end
            NEG_B: begin add_b = rs2_q; add_sub = 1'b1; end
            ITER: begin
                add_a   = is_div ? rp[XLEN-1:0] : hi;
                add_b   = mcand;
                add_sub = is_div;
            end
            NEG_R: begin add_b = res_pre; add_sub = 1'b1; end
            default: ;
        endcase
    end

    assign mag = (state == NEG_A) ? (s1n ? sum : rs1_q) : (s2n ? sum : rs2_q);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = start_tgt;
            NEG_A: begin busy = 1'b1; state_nxt = NEG_B; end
            NEG_B: begin busy = 1'b1; state_nxt = ITER; end
            ITER: begin
                busy = 1'b1;
                if (cnt == 5'(ITERS - 1)) state_nxt = NEG_R;
            end
            NEG_R: begin busy = 1'b1; state_nxt = DONE; end
            SKIP:  begin busy = 1'b1; state_nxt = DONE; end
            DONE: begin
                done      = 1'b1;
                state_nxt = bus.start ? start_tgt : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0; rs1_q <= '0; rs2_q <= '0; s1n <= 1'b0; s2n <= 1'b0;
            hi <= '0; lo <= '0; mcand <= '0; cnt <= '0; result_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE, DONE: if (bus.start) begin
                    op_q  <= bus.op;
                    rs1_q <= bus.rs1;
                    rs2_q <= bus.rs2;
                    s1n   <= rs1_is_signed(bus.op) & bus.rs1[XLEN-1];
                    s2n   <= rs2_is_signed(bus.op) & bus.rs2[XLEN-1];
                end
                NEG_A: lo <= mag;
                NEG_B: begin
                    // divide keeps |rs1| in Q and takes |rs2| as divisor; multiply swaps them
                    mcand <= is_div ? mag : lo;
                    if (!is_div) lo <= mag;
                    hi  <= '0;
                    cnt <= '0;
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        hi <= (rp[XLEN] || cout) ? sum : rp[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], rp[XLEN] || cout};
                    end else begin
                        hi <= mul_acc[XLEN:1];
                        lo <= {mul_acc[0], lo[XLEN-1:1]};
                    end
                end
                NEG_R: result_q <= res_fin;
                SKIP:  result_q <= early_res;
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;

endmodule
